subtractor_borrow_serial_amisha: RTL and testbench



---
 rtl/subtractor_borrow_serial_amisha_pkg.sv | 27 ++
 rtl/subtractor_borrow_serial_amisha_full_subtractor.sv | 16 +
 rtl/subtractor_borrow_serial_amisha.sv | 125 ++++++++++++
 tb/tb_subtractor_borrow_serial_amisha.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/subtractor_borrow_serial_amisha_pkg.sv
// Shared definitions for the bit-serial borrow subtractor: state encoding,
// default operand width and the counter-width helper.
package subtractor_pkg_amisha;

  // Controller states; the encoding is owned here so every user agrees on it.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Default operand/result width in bits.
  localparam int DEFAULT_WIDTH = 4;

  // Ceiling log2, never below 1 so a counter always has at least one bit.
  function automatic int clog2(input int value);
    int result;
    result = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/subtractor_borrow_serial_amisha_full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow out.
module full_subtractor_amisha (
  input  logic a_i,
  input  logic b_i,
  input  logic bin_i,
  output logic d_o,
  output logic bout_o
);

  // Difference bit and borrow propagation for a single bit position.
  always_comb begin
    d_o    = a_i ^ b_i ^ bin_i;
    bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);
  end

endmodule

// File: rtl/subtractor_borrow_serial_amisha.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b), LSB first, one bit per
// clock, with start/busy/done handshake, unsigned borrow-out and signed
// overflow reporting.
module subtractor_borrow_serial_amisha
  import subtractor_pkg_amisha::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk_amisha,
  input  logic             rst_n_amisha,
  input  logic             start_amisha,
  input  logic [WIDTH-1:0] a_amisha,
  input  logic [WIDTH-1:0] b_amisha,
  output logic             busy_amisha,
  output logic             done_amisha,
  output logic [WIDTH-1:0] diff_amisha,
  output logic             bout_amisha,
  output logic             ovf_amisha
);

  localparam int             CW       = clog2(WIDTH);
  localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

  state_e            state_q;
  logic [CW-1:0]     cnt_q;
  logic [CW-1:0]     cnt_d;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic              a_msb_q;
  logic              b_msb_q;
  logic              br_q;
  logic [WIDTH-1:0]  res_q;
  logic [WIDTH-1:0]  res_d;
  logic              bit_d;
  logic              br_d;
  logic              busy_q;
  logic              done_q;
  logic [WIDTH-1:0]  diff_q;
  logic              bout_q;
  logic              ovf_q;

  // The single cell sees the current LSBs of the operand shift registers.
  full_subtractor_amisha u_cell (
    .a_i    (a_q[0]),
    .b_i    (b_q[0]),
    .bin_i  (br_q),
    .d_o    (bit_d),
    .bout_o (br_d)
  );

  // Next result word (new bit enters at the MSB) and next counter value.
  always_comb begin
    res_d = {bit_d, res_q[WIDTH-1:1]};
    cnt_d = cnt_q + 1'b1;
  end

  // Controller, operand/result shift registers and registered outputs.
  always_ff @(posedge clk_amisha or negedge rst_n_amisha) begin
    if (!rst_n_amisha) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      br_q    <= 1'b0;
      res_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start_amisha) begin
            a_q     <= a_amisha;
            b_q     <= b_amisha;
            // Operand sign bits are kept aside because the shift
            // registers drain them before the overflow decision.
            a_msb_q <= a_amisha[WIDTH-1];
            b_msb_q <= b_amisha[WIDTH-1];
            br_q    <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          res_q <= res_d;
          br_q  <= br_d;
          cnt_q <= cnt_d;
          if (cnt_q == LAST_CNT) begin
            diff_q  <= res_d;
            bout_q  <= br_d;
            // bit_d is the result MSB on the final step.
            ovf_q   <= (a_msb_q != b_msb_q) & (bit_d != a_msb_q);
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy_amisha = busy_q;
  assign done_amisha = done_q;
  assign diff_amisha = diff_q;
  assign bout_amisha = bout_q;
  assign ovf_amisha  = ovf_q;

endmodule

// File: tb/tb_subtractor_borrow_serial_amisha.sv
// Self-checking bench for the bit-serial subtractor at WIDTH=4 and WIDTH=8.
module tb_subtractor_borrow_serial_amisha;

  logic       clk;
  logic       rst_n;

  logic       start4;
  logic [3:0] a4, b4;
  logic       busy4, done4;
  logic [3:0] diff4;
  logic       bout4, ovf4;

  logic       start8;
  logic [7:0] a8, b8;
  logic       busy8, done8;
  logic [7:0] diff8;
  logic       bout8, ovf8;

  int n_checks = 0;
  int n_errors = 0;

  subtractor_borrow_serial_amisha #(.WIDTH(4)) u_dut4 (
    .clk_amisha   (clk),
    .rst_n_amisha (rst_n),
    .start_amisha (start4),
    .a_amisha     (a4),
    .b_amisha     (b4),
    .busy_amisha  (busy4),
    .done_amisha  (done4),
    .diff_amisha  (diff4),
    .bout_amisha  (bout4),
    .ovf_amisha   (ovf4)
  );

  subtractor_borrow_serial_amisha #(.WIDTH(8)) u_dut8 (
    .clk_amisha   (clk),
    .rst_n_amisha (rst_n),
    .start_amisha (start8),
    .a_amisha     (a8),
    .b_amisha     (b8),
    .busy_amisha  (busy8),
    .done_amisha  (done8),
    .diff_amisha  (diff8),
    .bout_amisha  (bout8),
    .ovf_amisha   (ovf8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views.
  function automatic void model(input int w, input int a, input int b,
                                output int d, output int bo, output int ov);
    int m;
    int sa;
    int sb;
    int r;
    m  = 1 << w;
    sa = (a >= m / 2) ? a - m : a;
    sb = (b >= m / 2) ? b - m : b;
    r  = sa - sb;
    d  = ((a - b) % m + m) % m;
    bo = (a < b) ? 1 : 0;
    ov = (r < -(m / 2) || r > (m / 2 - 1)) ? 1 : 0;
  endfunction

  task automatic drive(input int w, input logic s, input int a, input int b);
    if (w == 8) begin
      start8 = s; a8 = 8'(a); b8 = 8'(b);
    end else begin
      start4 = s; a4 = 4'(a); b4 = 4'(b);
    end
  endtask

  function automatic logic get_done(input int w);
    return (w == 8) ? done8 : done4;
  endfunction
  function automatic logic get_busy(input int w);
    return (w == 8) ? busy8 : busy4;
  endfunction
  function automatic logic [31:0] get_diff(input int w);
    return (w == 8) ? 32'(diff8) : 32'(diff4);
  endfunction
  function automatic logic get_bout(input int w);
    return (w == 8) ? bout8 : bout4;
  endfunction
  function automatic logic get_ovf(input int w);
    return (w == 8) ? ovf8 : ovf4;
  endfunction

  // Wait (bounded) for done; returns edges counted since the accepting edge, 0 on timeout.
  task automatic wait_done(input int w, output int lat);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      drive(w, 1'b0, int'($urandom), int'($urandom));
      @(posedge clk); #1;
      if (get_done(w)) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic run_op(input int w, input int a, input int b);
    int ed, eb, eo, lat;
    @(negedge clk);
    drive(w, 1'b1, a, b);
    @(posedge clk); #1;
    check_val("busy_after_accept", 32'(get_busy(w)), 32'd1);
    wait_done(w, lat);
    model(w, a, b, ed, eb, eo);
    check_val("latency", lat, w);
    check_val("diff", get_diff(w), ed);
    check_val("bout", 32'(get_bout(w)), eb);
    check_val("ovf", 32'(get_ovf(w)), eo);
    $display("op w=%0d a=0x%0h b=0x%0h -> diff=0x%0h bout=%0d ovf=%0d lat=%0d",
             w, a, b, get_diff(w), get_bout(w), get_ovf(w), lat);
    @(posedge clk); #1;
    check_val("done_one_cycle", 32'(get_done(w)), 32'd0);
    check_val("busy_cleared", 32'(get_busy(w)), 32'd0);
  endtask

  initial begin
    int lat, ed, eb, eo, na, nb, ndone;
    rst_n = 1'b0;
    drive(4, 1'b0, 0, 0);
    drive(8, 1'b0, 0, 0);
    #23;
    check_val("rst_busy", 32'(busy4), 32'd0);
    check_val("rst_done", 32'(done4), 32'd0);
    check_val("rst_diff", 32'(diff4), 32'd0);
    check_val("rst_bout", 32'(bout4), 32'd0);
    check_val("rst_ovf", 32'(ovf4), 32'd0);
    check_val("rst_diff8", 32'(diff8), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases.
    run_op(4, 4'b0000, 4'b0111);
    run_op(4, 4'b0100, 4'b1100);
    run_op(4, 4'b1101, 4'b1111);
    run_op(4, 4'b1000, 4'b0001);

    // Results hold while idle.
    repeat (3) @(posedge clk);
    #1;
    check_val("idle_hold_diff", 32'(diff4), 32'd7);
    check_val("idle_hold_ovf", 32'(ovf4), 32'd1);

    // Start held high: 7-7 with operands toggling during RUN, then a re-accept at EWIDTH+2.
    @(negedge clk);
    drive(4, 1'b1, 7, 7);
    @(posedge clk); #1;
    ndone = 0;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      a4 = 4'($urandom);
      b4 = 4'($urandom);
      @(posedge clk); #1;
      if (done4) begin
        ndone++;
        lat = k;
        break;
      end
    end
    check_val("hold_latency", lat, 4);
    check_val("hold_diff", 32'(diff4), 32'd0);
    check_val("hold_bout", 32'(bout4), 32'd0);
    check_val("hold_ovf", 32'(ovf4), 32'd0);
    $display("op w=4 a=0x7 b=0x7 (start held) -> diff=0x%0h bout=%0d ovf=%0d lat=%0d", diff4, bout4, ovf4, lat);
    na = int'($urandom_range(15, 0));
    nb = int'($urandom_range(15, 0));
    @(negedge clk);
    a4 = 4'(na);
    b4 = 4'(nb);
    @(posedge clk); #1;
    check_val("hold_no_accept_ewidth1", 32'(busy4), 32'd0);
    check_val("hold_done_low", 32'(done4), 32'd0);
    @(posedge clk); #1;
    check_val("hold_accept_ewidth2", 32'(busy4), 32'd1);
    start4 = 1'b0;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      a4 = 4'($urandom);
      b4 = 4'($urandom);
      @(posedge clk); #1;
      if (done4) begin
        ndone++;
        lat = k;
        break;
      end
    end
    model(4, na, nb, ed, eb, eo);
    check_val("b2b_latency", lat, 4);
    check_val("b2b_diff", 32'(diff4), ed);
    check_val("b2b_bout", 32'(bout4), eb);
    check_val("b2b_ovf", 32'(ovf4), eo);
    check_val("b2b_done_count", ndone, 2);
    $display("op w=4 a=0x%0h b=0x%0h (back-to-back) -> diff=0x%0h bout=%0d ovf=%0d", na, nb, diff4, bout4, ovf4);
    @(posedge clk); #1;
    check_val("b2b_done_one_cycle", 32'(done4), 32'd0);

    // Reset asserted at E2 of 5-9: operation abandoned, outputs cleared.
    @(negedge clk);
    drive(4, 1'b1, 5, 9);
    @(posedge clk); #1;
    start4 = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_val("midrst_busy", 32'(busy4), 32'd0);
    check_val("midrst_done", 32'(done4), 32'd0);
    check_val("midrst_diff", 32'(diff4), 32'd0);
    check_val("midrst_bout", 32'(bout4), 32'd0);
    check_val("midrst_ovf", 32'(ovf4), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (done4) ndone++;
    end
    check_val("midrst_no_done", ndone, 0);
    $display("op w=4 a=0x5 b=0x9 abandoned by reset, dones=%0d", ndone);
    run_op(4, 4'b0101, 4'b1001);

    // Wider instance.
    run_op(8, 8'h00, 8'h01);
    for (int i = 0; i < 10; i++) begin
      run_op(8, int'($urandom_range(255, 0)), int'($urandom_range(255, 0)));
    end

    // Exhaustive 4-bit sweep, then random extras.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        run_op(4, a, b);
      end
    end
    for (int i = 0; i < 20; i++) begin
      run_op(4, int'($urandom_range(15, 0)), int'($urandom_range(15, 0)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
